// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: WIDTH-bit add/sub with carry/borrow, signed-overflow and zero flags; optional ADDSUB_SAT_EN saturation.
// Latency STAGES cycles at one op/cycle; the whole pipe holds while out_valid=1 and out_ready=0 (in_ready low).
module alu_addsub_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf,
   output logic             zero
);

   typedef struct packed {
      logic [WIDTH:0] sum;
      logic           ovf;
      logic           zero;
   } res_t;

   if (WIDTH < 4 || WIDTH > 32 || STAGES < 1 || STAGES > 4) begin : g_param_check
      $error("alu_addsub_pipe: WIDTH must be 4..32 and STAGES 1..4");
   end

   logic             en;
   logic             take;
   logic [WIDTH:0]   raw;
   logic [WIDTH-1:0] low;
   logic             ovf_c;
   res_t             res_d;

   res_t             dat [STAGES];
   logic [STAGES-1:0] vld;

   assign out_valid = vld[STAGES-1];
   assign en        = out_ready | ~out_valid;
   assign in_ready  = en;
   assign take      = in_valid & en;

   // The extra MSB of the WIDTH+1 subtraction is exactly the unsigned borrow.
   always_comb begin
      raw   = '0;
      low   = '0;
      ovf_c = 1'b0;
      res_d = '0;
      if (op) begin
         raw = {1'b0, x} - {1'b0, y};
      end else begin
         raw = {1'b0, x} + {1'b0, y};
      end
      low = raw[WIDTH-1:0];
      if (op) begin
         ovf_c = (x[WIDTH-1] != y[WIDTH-1]) && (low[WIDTH-1] != x[WIDTH-1]);
      end else begin
         ovf_c = (x[WIDTH-1] == y[WIDTH-1]) && (low[WIDTH-1] != x[WIDTH-1]);
      end
`ifdef ADDSUB_SAT_EN
      if (raw[WIDTH]) begin
         low = op ? '0 : '1;
      end
`endif
      res_d.sum  = {raw[WIDTH], low};
      res_d.ovf  = ovf_c;
      res_d.zero = ~|low;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
         end
      end else if (en) begin
         vld[0] <= take;
         dat[0] <= res_d;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign sum  = dat[STAGES-1].sum;
   assign ovf  = dat[STAGES-1].ovf;
   assign zero = dat[STAGES-1].zero;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed + constrained-random bench for alu_addsub_pipe (WIDTH=8, STAGES=2) with a queue scoreboard.
module tb_alu_addsub_pipe;

   typedef struct packed {
      logic [8:0] sum;
      logic       ovf;
      logic       zero;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       op;
   logic [7:0] x;
   logic [7:0] y;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] sum;
   logic       ovf;
   logic       zero;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   stall_left = 0;
   int   stall_seen = 0;
   bit   rand_ordy = 1'b0;
   bit   acc;
   exp_t sb[$];

   logic       hold_pend = 1'b0;
   logic [8:0] hold_sum;
   logic       hold_ovf;
   logic       hold_zero;

   alu_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
      exp_t       e;
      int         r;
      logic [7:0] lo;
      logic       c;
      if (!o) begin
         r = int'(a) + int'(b);
         c = (r > 255);
      end else begin
         r = int'(a) - int'(b);
         c = (a < b);
      end
      lo = r[7:0];
      if (!o) e.ovf = (a[7] == b[7]) && (lo[7] != a[7]);
      else    e.ovf = (a[7] != b[7]) && (lo[7] != a[7]);
`ifdef ADDSUB_SAT_EN
      if (c) lo = o ? 8'h00 : 8'hFF;
`endif
      e.sum  = {c, lo};
      e.zero = (lo == 8'h00);
      return e;
   endfunction

   // One clock: record a transfer at the sampling point, then update out_ready after the edge.
   task automatic step();
      @(negedge clk);
      acc = 1'b0;
      if (in_valid && in_ready) begin
         sb.push_back(model(op, x, y));
         acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_valid) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (rand_ordy) begin
         out_ready = 1'($urandom_range(0, 1));
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic drive(input logic o, input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      op = o;
      x  = a;
      y  = b;
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++) step();
      if (!acc) begin
         n_fail++;
         $display("FAIL accept_timeout: observed no transfer required transfer within 100 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() > 0; k++) step();
      chk("drain_empty", sb.size(), 0);
   endtask

   // Output-side checker: scoreboard pops on transfers, holds checked while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, hold_sum);
            chk("hold_flags", {ovf, zero}, {hold_ovf, hold_zero});
         end
         hold_pend = 1'b0;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            stall_seen++;
            hold_pend = 1'b1;
            hold_sum  = sum;
            hold_ovf  = ovf;
            hold_zero = zero;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_sum", sum, e.sum);
               chk("sb_ovf", ovf, e.ovf);
               chk("sb_zero", zero, e.zero);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish required finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      op = 1'b0;
      x = '0;
      y = '0;
      out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sum", sum, 0);
      chk("rst_flags", {ovf, zero}, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      // 200+100: latency of two edges, explicit values
      drive(1'b0, 8'd200, 8'd100);
      chk("lat_not_yet", out_valid, 0);
      step();
      chk("lat_valid", out_valid, 1);
      chk("add200_100_sum", sum, 9'h12C);
      chk("add200_100_flags", {ovf, zero}, 2'b00);

      drive(1'b0, 8'd127, 8'd1);
      step();
      chk("add127_1_sum", sum, 9'h080);
      chk("add127_1_ovf", ovf, 1);

      drive(1'b0, 8'd255, 8'd1);
      step();
`ifdef ADDSUB_SAT_EN
      chk("add255_1_sum", sum, 9'h1FF);
      chk("add255_1_zero", zero, 0);
`else
      chk("add255_1_sum", sum, 9'h100);
      chk("add255_1_zero", zero, 1);
`endif

      drive(1'b1, 8'd5, 8'd7);
      step();
`ifdef ADDSUB_SAT_EN
      chk("sub5_7_sum", sum, 9'h100);
      chk("sub5_7_zero", zero, 1);
`else
      chk("sub5_7_sum", sum, 9'h1FE);
      chk("sub5_7_ovf", ovf, 0);
`endif

      drive(1'b1, 8'h80, 8'd1);
      step();
      chk("sub80_1_sum", sum, 9'h07F);
      chk("sub80_1_ovf", ovf, 1);
      drain();

      // Four back-to-back ops with a three-cycle output stall
      stall_seen = 0;
      stall_left = 3;
      drive(1'b0, 8'd10, 8'd20);
      drive(1'b1, 8'd50, 8'd60);
      drive(1'b0, 8'd128, 8'd128);
      drive(1'b1, 8'd9, 8'd9);
      drain();
      chk("stall_cycles", stall_seen, 3);

      // Random operands under random backpressure
      rand_ordy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      drain();
      rand_ordy = 1'b0;
      step();

      // Reset with two operations in flight
      drive(1'b0, 8'd1, 8'd2);
      drive(1'b0, 8'd3, 8'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_sum", sum, 0);
      chk("midrst_flags", {ovf, zero}, 0);
      sb.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_idle", out_valid, 0);
      end
      drive(1'b0, 8'd10, 8'd20);
      chk("post_rst_lat", out_valid, 0);
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_sum", sum, 9'h01E);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_addsub_pipe.md
ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter STAGES, default 2, number of register stages from input to output; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  x, y, op carry a valid operation this cycle.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 op  input  1  0 = add (x+y), 1 = subtract (x-y).
REQ-008 x  input  WIDTH  first operand.
REQ-009 y  input  WIDTH  second operand.
REQ-010 out_valid  output  1  sum/ovf/zero hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH+1  result; bit WIDTH = carry (add) or borrow (sub).
REQ-013 ovf  output  1  two's-complement signed overflow of the WIDTH-bit result.
REQ-014 zero  output  1  result bits [WIDTH-1:0] all zero.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer where out_valid and out_ready are both 1.
REQ-016 Pipeline enable en = out_ready OR NOT out_valid; in_ready SHALL equal en, combinationally.
REQ-017 When en=1 all STAGES slots (data plus valid bit) SHALL shift one position; slot 0 loads in_valid AND in_ready; when en=0 all slots SHALL hold.
REQ-018 Latency: with en held 1, a result accepted at edge N SHALL appear with out_valid=1 after edge N+STAGES-1 (STAGES cycles from sampling to visibility); throughput one operation per cycle.
REQ-019 Add: sum = zero-extended x + zero-extended y, WIDTH+1 bits, no truncation of carry.
REQ-020 Subtract: sum[WIDTH-1:0] = (x - y) mod 2^WIDTH; sum[WIDTH] = 1 iff x < y unsigned.
REQ-021 ovf SHALL be 1 for add when x, y share sign and result sign differs; for sub when x, y differ in sign and result sign differs from x.
REQ-022 Results SHALL leave in acceptance order; no operation dropped or duplicated under any out_ready pattern.
REQ-023 Bubbles (in_valid=0 while en=1) SHALL propagate as out_valid=0 slots; sum/ovf/zero are don't-care when out_valid=0 but SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Result data SHALL be computed before slot 0 register and carried unchanged through later slots.

Reset
REQ-025 rst_n=0 SHALL immediately clear all valid bits and data registers: out_valid=0, sum=0, ovf=0, zero=0.
REQ-026 in_ready SHALL read 1 during and after reset (all slots empty).
REQ-027 Reset mid-operation SHALL discard all in-flight operations; first result after release comes only from a post-release transfer.

Configuration
REQ-028 Macro ADDSUB_SAT_EN: when defined, sum[WIDTH-1:0] SHALL saturate unsigned: add with carry -> all ones; sub with borrow -> all zeros; sum[WIDTH] and ovf still report the raw carry/borrow and overflow; zero computed on saturated value.
REQ-029 When ADDSUB_SAT_EN is undefined, results SHALL wrap modulo 2^WIDTH per REQ-019/020; no saturation logic present.

Verification (WIDTH=8, STAGES=2)
REQ-030 add x=200,y=100, out_ready=1 -> 2 cycles later out_valid=1, sum=0x12C, ovf=0, zero=0.
REQ-031 add x=127,y=1 -> sum=0x080, ovf=1; add x=255,y=1 -> sum=0x100, zero=1 (without SAT) / sum=0x1FF, zero=0 (with ADDSUB_SAT_EN).
REQ-032 sub x=5,y=7 -> sum=0x1FE, ovf=0 (without SAT); sum=0x100, zero=1 (with SAT); sub x=0x80,y=1 -> sum=0x07F, ovf=1.
REQ-033 Stream 4 ops back-to-back, out_ready low 3 cycles while out_valid=1 -> in_ready=0 those cycles, result held stable, all 4 results delivered in order, none lost.
REQ-034 Assert rst_n=0 with 2 ops in flight -> out_valid=0 same cycle without clock edge; after release out_valid stays 0 until 2 cycles after a new transfer.
